mem_wb_stage: RTL and testbench

Memory-access stage and MEM/WB pipeline register of the five-stage MIPS pipeline. It consumes the fields delivered by the EX/MEM register, performs loads and stores against a data memory with a request/ready handshake, and stalls upstream while an access is outstanding. It registers the write-back fields for the WB stage, and flags misaligned accesses and memory timeouts.

---
 rtl/mem_wb_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage and MEM/WB pipeline register.
// Handshakes with data memory, stalls upstream during an access, flags misalignment and timeouts.
`timescale 1ns/1ps

module mem_wb_stage #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        RegWrite_in,
  input  logic        MemToReg_in,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [4:0]  WriteRegAddress_in,
  input  logic [31:0] NextInstruct_in,
  input  logic [31:0] Instruction_in,
  input  logic        ErrClr,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic        Stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUResult_out,
  output logic [4:0]  WriteRegAddress_out,
  output logic [31:0] NextInstruct_out,
  output logic [31:0] Instruction_out,
  output logic        AlignErr,
  output logic        BusErr
);

  // state | meaning
  // IDLE  | accepting EX/MEM fields; an aligned mem op launches a request
  // REQ   | DMemReq high, waiting for DMemReady or the timeout
  // DONE  | access finished; MEM/WB loads the held fields plus captured data
  typedef enum logic [1:0] {IDLE, REQ, DONE} stateT;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  stateT       state;
  stateT       stateNext;
  logic [15:0] waitCnt;
  logic [31:0] capData;

  logic memOp;
  logic misAligned;
  logic timeoutHit;
  logic stallInt;
  logic accStart;
  logic accDone;
  logic alignSet;
  logic busErrSet;

  assign memOp      = MemRead_in | MemWrite_in;
  assign misAligned = memOp & (ALUResult_in[1:0] != 2'b00);
  assign timeoutHit = (waitCnt == LAST_WAIT);
  assign alignSet   = (state == IDLE) & misAligned;

  always_comb begin
    stateNext = state;
    stallInt  = 1'b0;
    accStart  = 1'b0;
    accDone   = 1'b0;
    busErrSet = 1'b0;
    case (state)
      IDLE: begin
        if (memOp && !misAligned) begin
          stallInt  = 1'b1;
          accStart  = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        stallInt = 1'b1;
        if (DMemReady) begin
          accDone   = 1'b1;
          stateNext = DONE;
        end else if (timeoutHit) begin
          accDone   = 1'b1;
          busErrSet = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Gate with reset so a mem op presented during reset cannot stall upstream.
  assign Stall = stallInt & Rst;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      DMemReq   <= 1'b0;
      DMemWe    <= 1'b0;
      DMemAddr  <= 32'h0;
      DMemWData <= 32'h0;
      waitCnt   <= 16'h0;
      capData   <= 32'h0;
    end else if (accStart) begin
      DMemReq   <= 1'b1;
      DMemWe    <= MemWrite_in;
      DMemAddr  <= ALUResult_in;
      DMemWData <= ReadData2_in;
      waitCnt   <= 16'h0;
      capData   <= 32'h0;
    end else if (state == REQ) begin
      waitCnt <= waitCnt + 16'h1;
      if (accDone) begin
        DMemReq <= 1'b0;
        if (busErrSet) begin
          capData <= ERR_DATA;
        end else if (!DMemWe) begin
          capData <= DMemRData;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      RegWrite_out        <= 1'b0;
      MemToReg_out        <= 1'b0;
      ReadData_out        <= 32'h0;
      ALUResult_out       <= 32'h0;
      WriteRegAddress_out <= 5'h0;
      NextInstruct_out    <= 32'h0;
      Instruction_out     <= 32'h0;
    end else if (stallInt) begin
      RegWrite_out <= 1'b0;
      MemToReg_out <= 1'b0;
    end else begin
      RegWrite_out        <= RegWrite_in & ~alignSet;
      MemToReg_out        <= MemToReg_in;
      ReadData_out        <= (state == DONE) ? capData : 32'h0;
      ALUResult_out       <= ALUResult_in;
      WriteRegAddress_out <= WriteRegAddress_in;
      NextInstruct_out    <= NextInstruct_in;
      Instruction_out     <= Instruction_in;
    end
  end

  // A fresh error wins over a simultaneous clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      AlignErr <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      AlignErr <= alignSet  | (AlignErr & ~ErrClr);
      BusErr   <= busErrSet | (BusErr   & ~ErrClr);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes expected MEM/WB results,
// a monitor pops them at each non-stalled edge, and a memory responder models DMem.
`timescale 1ns/1ps

module tb_mem_wb_stage;

  localparam int unsigned TO   = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, RegWrite_in = 1'b0, MemToReg_in = 1'b0;
  logic [31:0] ALUResult_in = '0, ReadData2_in = '0, NextInstruct_in = '0, Instruction_in = '0;
  logic [4:0]  WriteRegAddress_in = '0;
  logic        ErrClr = 1'b0;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic [31:0] DMemRData;
  logic        DMemReady;
  logic        Stall;
  logic        RegWrite_out, MemToReg_out;
  logic [31:0] ReadData_out, ALUResult_out, NextInstruct_out, Instruction_out;
  logic [4:0]  WriteRegAddress_out;
  logic        AlignErr, BusErr;

  always #5 Clk = ~Clk;

  mem_wb_stage #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .Clk(Clk), .Rst(Rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
    .WriteRegAddress_in(WriteRegAddress_in),
    .NextInstruct_in(NextInstruct_in), .Instruction_in(Instruction_in),
    .ErrClr(ErrClr),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemRData(DMemRData), .DMemReady(DMemReady),
    .Stall(Stall),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
    .WriteRegAddress_out(WriteRegAddress_out),
    .NextInstruct_out(NextInstruct_out), .Instruction_out(Instruction_out),
    .AlignErr(AlignErr), .BusErr(BusErr)
  );

  typedef struct packed {
    logic        rd, wr, rw, m2r;
    logic [31:0] alu, wd;
    logic [4:0]  wa;
    logic [31:0] npc, ins;
    logic        clr;
  } instT;

  typedef struct packed {
    logic        rw, m2r;
    logic [31:0] rdata, alu;
    logic [4:0]  wa;
    logic [31:0] npc, ins;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: asserts DMemReady in REQ cycle waitCfg (0-based); random noise otherwise.
  int          waitCfg = 0;
  logic [31:0] memData = '0;
  int          reqCyc = 0, pulses = 0, lastLen = 0;
  logic [31:0] pAddr = '0, pWData = '0;
  logic        pWe = 1'b0;
  logic        unstable = 1'b0;

  initial begin
    DMemReady = 1'b0;
    DMemRData = '0;
    forever begin
      @(negedge Clk);
      if (Rst && DMemReq) begin
        if (reqCyc == 0) begin
          pulses++;
          pAddr    = DMemAddr;
          pWData   = DMemWData;
          pWe      = DMemWe;
          unstable = 1'b0;
        end else if (DMemAddr !== pAddr || DMemWData !== pWData || DMemWe !== pWe) begin
          unstable = 1'b1;
        end
        DMemReady = (reqCyc == waitCfg);
        DMemRData = DMemReady ? memData : $urandom;
        reqCyc++;
        lastLen = reqCyc;
      end else begin
        reqCyc    = 0;
        DMemReady = 1'($urandom_range(0, 1));
        DMemRData = $urandom;
      end
    end
  end

  function automatic instT mk(input logic rd, input logic wr, input logic rw, input logic m2r,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] wa, input logic clr);
    instT i;
    i.rd = rd; i.wr = wr; i.rw = rw; i.m2r = m2r;
    i.alu = alu; i.wd = wd; i.wa = wa; i.clr = clr;
    i.npc = $urandom;
    i.ins = $urandom;
    return i;
  endfunction

  task automatic apply(input instT i);
    MemRead_in = i.rd; MemWrite_in = i.wr; RegWrite_in = i.rw; MemToReg_in = i.m2r;
    ALUResult_in = i.alu; ReadData2_in = i.wd; WriteRegAddress_in = i.wa;
    NextInstruct_in = i.npc; Instruction_in = i.ins; ErrClr = i.clr;
  endtask

  task automatic drive(input instT i);
    expT  e;
    logic isMem, mis;
    apply(i);
    isMem   = i.rd | i.wr;
    mis     = isMem && (i.alu[1:0] != 2'b00);
    e.rw    = mis ? 1'b0 : i.rw;
    e.m2r   = i.m2r;
    e.alu   = i.alu;
    e.wa    = i.wa;
    e.npc   = i.npc;
    e.ins   = i.ins;
    if (!isMem || mis || i.wr) e.rdata = 32'h0;
    else if (waitCfg < int'(TO)) e.rdata = memData;
    else e.rdata = ERRD;
    sbQ.push_back(e);
  endtask

  // Present an instruction at a negedge and hold it until the DUT accepts it.
  task automatic issue(input instT i, output int stallCyc);
    @(negedge Clk);
    drive(i);
    Rst = 1'b1;
    stallCyc = 0;
    #2;
    while (Stall === 1'b1 && stallCyc < 50) begin
      stallCyc++;
      @(negedge Clk);
      #2;
    end
    if (stallCyc >= 50) chk("stall_bound", Stall, 0);
  endtask

  initial begin
    expT  e;
    logic sStall, sRst;
    forever begin
      @(negedge Clk);
      #2;
      sStall = Stall;
      sRst   = Rst;
      @(posedge Clk);
      #1;
      if (sRst && Rst) begin
        if (sStall) begin
          chk("bubble_rw", RegWrite_out, 0);
          chk("bubble_m2r", MemToReg_out, 0);
        end else begin
          chk("sb_nonempty", 32'(sbQ.size() != 0), 1);
          if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            chk("wb_rw", RegWrite_out, e.rw);
            chk("wb_m2r", MemToReg_out, e.m2r);
            chk("wb_rdata", ReadData_out, e.rdata);
            chk("wb_alu", ALUResult_out, e.alu);
            chk("wb_wa", WriteRegAddress_out, e.wa);
            chk("wb_npc", NextInstruct_out, e.npc);
            chk("wb_ins", Instruction_out, e.ins);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sc, p0, n;
    instT nop;
    nop = '0;

    #1 Rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      MemRead_in = 1'($urandom_range(0, 1));
      MemWrite_in = 1'($urandom_range(0, 1));
      RegWrite_in = 1'($urandom_range(0, 1));
      MemToReg_in = 1'($urandom_range(0, 1));
      ALUResult_in = $urandom & 32'hFFFF_FFFC;
      ReadData2_in = $urandom;
      WriteRegAddress_in = 5'($urandom);
      NextInstruct_in = $urandom;
      Instruction_in = $urandom;
      ErrClr = 1'($urandom_range(0, 1));
      #2;
      chk("rst_stall", Stall, 0);
      chk("rst_req", DMemReq, 0);
      chk("rst_dmem", DMemAddr | DMemWData | {31'b0, DMemWe}, 0);
      chk("rst_wb", ReadData_out | ALUResult_out | NextInstruct_out | Instruction_out |
                    {27'b0, WriteRegAddress_out} | {30'b0, RegWrite_out, MemToReg_out}, 0);
      chk("rst_err", {30'b0, AlignErr, BusErr}, 0);
    end

    issue(mk(0, 0, 1, 0, 32'h12, 32'h0, 5'd3, 0), sc);
    chk("alu_stall", sc, 0);
    issue(mk(0, 0, 1, 0, 32'h7777_0001, 32'h5, 5'd4, 0), sc);
    chk("alu2_stall", sc, 0);

    waitCfg = 0; memData = 32'hCAFE0001; p0 = pulses;
    issue(mk(1, 0, 1, 1, 32'h100, 32'h0, 5'd8, 0), sc);
    chk("lw_stall", sc, 2);
    chk("lw_pulses", pulses - p0, 1);
    chk("lw_len", lastLen, 1);
    chk("lw_we", pWe, 0);
    chk("lw_addr", pAddr, 32'h100);

    waitCfg = 3; p0 = pulses;
    issue(mk(0, 1, 0, 0, 32'h200, 32'hA5A5A5A5, 5'd9, 0), sc);
    chk("sw_stall", sc, 5);
    chk("sw_pulses", pulses - p0, 1);
    chk("sw_len", lastLen, 4);
    chk("sw_we", pWe, 1);
    chk("sw_addr", pAddr, 32'h200);
    chk("sw_wdata", pWData, 32'hA5A5A5A5);
    chk("sw_stable", unstable, 0);

    p0 = pulses;
    issue(mk(1, 0, 1, 1, 32'h102, 32'h0, 5'd10, 0), sc);
    chk("mis_stall", sc, 0);
    @(posedge Clk); #1;
    chk("mis_alignerr", AlignErr, 1);
    chk("mis_pulses", pulses - p0, 0);
    issue(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1), sc);
    @(posedge Clk); #1;
    chk("clr_alignerr", AlignErr, 0);
    issue(mk(0, 1, 1, 0, 32'h301, 32'h1, 5'd11, 1), sc);
    @(posedge Clk); #1;
    chk("clr_vs_set", AlignErr, 1);
    issue(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1), sc);
    @(posedge Clk); #1;
    chk("clr_alignerr2", AlignErr, 0);

    waitCfg = 1000; p0 = pulses;
    issue(mk(1, 0, 1, 1, 32'h400, 32'h0, 5'd12, 0), sc);
    chk("to_stall", sc, 5);
    chk("to_len", lastLen, 4);
    chk("to_pulses", pulses - p0, 1);
    @(posedge Clk); #1;
    chk("to_buserr", BusErr, 1);
    issue(mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 1), sc);
    @(posedge Clk); #1;
    chk("clr_buserr", BusErr, 0);

    waitCfg = 0; memData = 32'h1111_2222; p0 = pulses;
    issue(mk(1, 0, 1, 1, 32'h500, 32'h0, 5'd13, 0), sc);
    chk("b2b_stall_a", sc, 2);
    memData = 32'h3333_4444;
    issue(mk(1, 0, 1, 1, 32'h504, 32'h0, 5'd14, 0), sc);
    chk("b2b_stall_b", sc, 2);
    chk("b2b_addr", pAddr, 32'h504);
    chk("b2b_pulses", pulses - p0, 2);

    waitCfg = 100;
    @(negedge Clk);
    apply(mk(1, 0, 1, 1, 32'h600, 32'h0, 5'd15, 0));
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (DMemReq !== 1'b1 && n < 10);
    chk("mid_req_seen", DMemReq, 1);
    #3 Rst = 1'b0;
    #1;
    chk("mid_req_drop", DMemReq, 0);
    chk("mid_stall", Stall, 0);
    @(negedge Clk);
    apply(nop);
    waitCfg = 1; memData = 32'h1357_9BDF; p0 = pulses;
    issue(mk(1, 0, 1, 1, 32'h700, 32'h0, 5'd16, 0), sc);
    chk("post_rst_stall", sc, 3);
    chk("post_rst_pulses", pulses - p0, 1);
    chk("post_rst_addr", pAddr, 32'h700);

    issue(mk(0, 0, 1, 0, 32'hABCD, 32'h0, 5'd17, 0), sc);
    @(posedge Clk); #2;
    chk("sb_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
